// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous SRAM between CPU
// instruction fetch (IF), CPU load/store (LS) and a debug/loader port (DBG).
// Fixed priority DBG > LS > IF, with IF promoted over LS after a run of
// denied cycles, an exclusive debug lock mode, and a sticky end-of-program
// flag raised by a write of DONE_VALUE to DONE_ADDR.
`timescale 1ns/1ps

module mem_port_arbiter #(
  parameter int unsigned         ADDR_W       = 16,
  parameter int unsigned         DATA_W       = 32,
  parameter int unsigned         STARVE_LIMIT = 4,
  parameter logic [ADDR_W-1:0]   DONE_ADDR    = 16'hFFFF,
  parameter logic [DATA_W-1:0]   DONE_VALUE   = 32'hFFFF_F000
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch (read only)
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // load/store
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  // debug / loader
  input  logic              dbg_lock,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  // SRAM side
  output logic              mem_enable,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out,
  // status
  output logic              done,
  output logic              locked
);

  typedef enum logic {ST_NORMAL = 1'b0, ST_LOCKED = 1'b1} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_LS = 2'd2, OWN_DBG = 2'd3} owner_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t     state_q;
  logic       locked_q;
  logic [3:0] starve_q, starve_d;
  owner_t     owner_q, owner_d;
  logic       done_q, done_d;
  logic       promote_if;

  assign promote_if = (starve_q == STARVE_MAX);

  // Grant selection and SRAM request mux; everything is forced idle during reset.
  always_comb begin
    if_gnt      = 1'b0;
    ls_gnt      = 1'b0;
    dbg_gnt     = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_in      = '0;
    if (!rst) begin
      if (dbg_req) begin
        dbg_gnt = 1'b1;
      end else if (state_q == ST_NORMAL) begin
        if (promote_if && if_req) begin
          if_gnt = 1'b1;
        end else if (ls_req) begin
          ls_gnt = 1'b1;
        end else if (if_req) begin
          if_gnt = 1'b1;
        end
      end
    end
    if (dbg_gnt) begin
      mem_write   = dbg_we;
      mem_address = dbg_addr;
      mem_in      = dbg_wdata;
    end else if (ls_gnt) begin
      mem_write   = ls_we;
      mem_address = ls_addr;
      mem_in      = ls_wdata;
    end else if (if_gnt) begin
      mem_address = if_addr;
    end
  end

  assign mem_enable = if_gnt | ls_gnt | dbg_gnt;

  // Next values for the starvation counter, read owner tag and finish flag.
  always_comb begin
    starve_d = starve_q;
    if (state_q == ST_LOCKED || !if_req || if_gnt) begin
      starve_d = 4'd0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + 4'd1;
    end

    owner_d = OWN_NONE;
    if (dbg_gnt && !dbg_we) begin
      owner_d = OWN_DBG;
    end else if (ls_gnt && !ls_we) begin
      owner_d = OWN_LS;
    end else if (if_gnt) begin
      owner_d = OWN_IF;
    end

    done_d = done_q;
    if (mem_enable && mem_write && (mem_address == DONE_ADDR) && (mem_in == DONE_VALUE)) begin
      done_d = 1'b1;
    end
  end

  // Lock FSM with registered locked output, plus all control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_NORMAL;
      locked_q <= 1'b0;
      starve_q <= 4'd0;
      owner_q  <= OWN_NONE;
      done_q   <= 1'b0;
    end else begin
      if (state_q == ST_NORMAL) begin
        if (dbg_lock) begin
          state_q  <= ST_LOCKED;
          locked_q <= 1'b1;
        end
      end else begin
        if (!dbg_lock) begin
          state_q  <= ST_NORMAL;
          locked_q <= 1'b0;
        end
      end
      starve_q <= starve_d;
      owner_q  <= owner_d;
      done_q   <= done_d;
    end
  end

  // A read granted just before reset must not report valid data while reset
  // is high, so the decoded owner tag is gated by rst.
  assign if_rvalid  = (owner_q == OWN_IF)  && !rst;
  assign ls_rvalid  = (owner_q == OWN_LS)  && !rst;
  assign dbg_rvalid = (owner_q == OWN_DBG) && !rst;

  assign if_rdata  = mem_out;
  assign ls_rdata  = mem_out;
  assign dbg_rdata = mem_out;

  assign done   = done_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed stimulus pushes expected grants and
// read returns into queues; a negedge monitor pops and compares them.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, ls_req, ls_we, dbg_lock, dbg_req, dbg_we;
  logic [AW-1:0] if_addr, ls_addr, dbg_addr;
  logic [DW-1:0] ls_wdata, dbg_wdata;
  logic          if_gnt, ls_gnt, dbg_gnt;
  logic          if_rvalid, ls_rvalid, dbg_rvalid;
  logic [DW-1:0] if_rdata, ls_rdata, dbg_rdata;
  logic          mem_enable, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_in, mem_out;
  logic          done, locked;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .dbg_lock(dbg_lock), .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_enable(mem_enable), .mem_write(mem_write),
    .mem_address(mem_address), .mem_in(mem_in), .mem_out(mem_out),
    .done(done), .locked(locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // SRAM model: preset contents for a few addresses, writes override them.
  logic [DW-1:0] mem   [0:65535];
  bit            wrote [0:65535];

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    case (a)
      16'h0010: rom = 32'h0000_0013;
      16'h0020: rom = 32'hA5A5_0020;
      16'h0030: rom = 32'h5A5A_0030;
      default:  rom = {16'hC0DE, a};
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_enable) begin
      if (mem_write) begin
        mem[mem_address]   <= mem_in;
        wrote[mem_address] <= 1'b1;
      end else begin
        mem_out <= wrote[mem_address] ? mem[mem_address] : rom(mem_address);
      end
    end
  end

  // Scoreboard queues. gnt bits are {dbg, ls, if}.
  typedef struct {
    int            cyc;
    logic [2:0]    gnt;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } gexp_t;

  typedef struct {
    int            cyc;
    logic [2:0]    port;
    logic [DW-1:0] data;
  } rexp_t;

  gexp_t exp_g[$];
  rexp_t exp_r[$];

  function automatic void exp_gnt(input logic [2:0] g, input logic we,
                                  input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_g.push_back('{cyc, g, we, a, d});
  endfunction

  function automatic void exp_rd(input logic [2:0] p, input logic [DW-1:0] d);
    exp_r.push_back('{cyc + 1, p, d});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got %h want %h", name, cyc, act, want);
    end
  endtask

  // Monitor: compare grants and read returns whenever the DUT presents them.
  always @(negedge clk) begin : monitor
    logic [2:0]    g, rv;
    logic [DW-1:0] rd;
    gexp_t         e;
    rexp_t         r;
    g  = {dbg_gnt, ls_gnt, if_gnt};
    rv = {dbg_rvalid, ls_rvalid, if_rvalid};
    if (rst) begin
      checks++;
      if (g != 3'b000 || mem_enable) begin
        errors++;
        $display("FAIL rst_gate cyc=%0d got gnt=%b en=%b want gnt=000 en=0", cyc, g, mem_enable);
      end
    end else if (mem_enable || g != 3'b000) begin
      checks++;
      if (exp_g.size() == 0) begin
        errors++;
        $display("FAIL gnt_unexpected cyc=%0d got gnt=%b en=%b addr=%h want none", cyc, g, mem_enable, mem_address);
      end else begin
        e = exp_g.pop_front();
        if (e.cyc != cyc || e.gnt != g || !mem_enable || mem_write != e.we ||
            mem_address != e.addr || (e.we && mem_in != e.wd)) begin
          errors++;
          $display("FAIL gnt cyc=%0d got gnt=%b en=%b we=%b addr=%h din=%h want cyc=%0d gnt=%b en=1 we=%b addr=%h din=%h",
                   cyc, g, mem_enable, mem_write, mem_address, mem_in, e.cyc, e.gnt, e.we, e.addr, e.wd);
        end
      end
    end
    if (rv != 3'b000) begin
      checks++;
      rd = rv[2] ? dbg_rdata : (rv[1] ? ls_rdata : if_rdata);
      if (exp_r.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected cyc=%0d got rvalid=%b data=%h want none", cyc, rv, rd);
      end else begin
        r = exp_r.pop_front();
        if (r.cyc != cyc || r.port != rv || rd != r.data) begin
          errors++;
          $display("FAIL rvalid cyc=%0d got rvalid=%b data=%h want cyc=%0d rvalid=%b data=%h",
                   cyc, rv, rd, r.cyc, r.port, r.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req  = 1'b0;
    ls_req  = 1'b0;
    ls_we   = 1'b0;
    dbg_req = 1'b0;
    dbg_we  = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    dbg_lock  = 1'b0;
    if_addr   = '0;
    ls_addr   = '0;
    dbg_addr  = '0;
    ls_wdata  = '0;
    dbg_wdata = '0;
    idle();
    tick();
    tick();
    chk("reset_locked", {31'b0, locked}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_rvalid", {29'b0, dbg_rvalid, ls_rvalid, if_rvalid}, 32'd0);
    tick();
    rst = 1'b0;

    // Single IF read: same-cycle grant, data one cycle later for one cycle.
    tick();
    if_req = 1'b1; if_addr = 16'h0010;
    exp_gnt(3'b001, 1'b0, 16'h0010, '0); exp_rd(3'b001, 32'h0000_0013);
    tick();
    idle();
    tick();

    // LS and IF both held: IF promoted after four denied cycles.
    for (int c = 0; c < 10; c++) begin
      tick();
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0020;
      if_req = 1'b1; if_addr = 16'h0030;
      if (c == 4 || c == 9) begin
        exp_gnt(3'b001, 1'b0, 16'h0030, '0); exp_rd(3'b001, 32'h5A5A_0030);
      end else begin
        exp_gnt(3'b010, 1'b0, 16'h0020, '0); exp_rd(3'b010, 32'hA5A5_0020);
      end
    end
    tick();
    idle();

    // Debug lock: rise cycle still grants IF, then only DBG is served.
    tick();
    if_req = 1'b1; if_addr = 16'h0030; dbg_lock = 1'b1;
    exp_gnt(3'b001, 1'b0, 16'h0030, '0); exp_rd(3'b001, 32'h5A5A_0030);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("locked_set", {31'b0, locked}, 32'd1);
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'(i); dbg_wdata = 32'h1000_0000 + 32'(i);
      exp_gnt(3'b100, 1'b1, 16'(i), 32'h1000_0000 + 32'(i));
    end
    tick();
    dbg_we = 1'b0; dbg_addr = 16'h0001;
    exp_gnt(3'b100, 1'b0, 16'h0001, '0); exp_rd(3'b100, 32'h1000_0001);
    tick();
    dbg_req = 1'b0;
    tick();
    dbg_lock = 1'b0;
    chk("locked_hold", {31'b0, locked}, 32'd1);
    tick();
    chk("locked_clear", {31'b0, locked}, 32'd0);
    if_addr = 16'h0002;
    exp_gnt(3'b001, 1'b0, 16'h0002, '0); exp_rd(3'b001, 32'h1000_0002);
    tick();
    idle();

    // Finish flag: only the exact value at the exact address sets it.
    tick();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'hFFFF; ls_wdata = 32'h1234_5678;
    exp_gnt(3'b010, 1'b1, 16'hFFFF, 32'h1234_5678);
    tick();
    chk("done_wrong_value", {31'b0, done}, 32'd0);
    ls_addr = 16'hFFFE; ls_wdata = 32'hFFFF_F000;
    exp_gnt(3'b010, 1'b1, 16'hFFFE, 32'hFFFF_F000);
    tick();
    chk("done_wrong_addr", {31'b0, done}, 32'd0);
    ls_addr = 16'hFFFF; ls_wdata = 32'hFFFF_F000;
    exp_gnt(3'b010, 1'b1, 16'hFFFF, 32'hFFFF_F000);
    tick();
    chk("done_set", {31'b0, done}, 32'd1);
    ls_wdata = 32'h0000_0000;
    exp_gnt(3'b010, 1'b1, 16'hFFFF, 32'h0000_0000);
    tick();
    chk("done_sticky", {31'b0, done}, 32'd1);
    // LS read followed immediately by reset: no rvalid may appear.
    ls_we = 1'b0; ls_addr = 16'h0020;
    exp_gnt(3'b010, 1'b0, 16'h0020, '0);
    tick();
    rst = 1'b1; if_req = 1'b1; dbg_req = 1'b1;
    tick();
    chk("done_rst", {31'b0, done}, 32'd0);
    chk("locked_rst", {31'b0, locked}, 32'd0);
    tick();
    rst = 1'b0;
    idle();

    // All three request together: DBG first, then LS once DBG drops.
    tick();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0003;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0020;
    if_req = 1'b1; if_addr = 16'h0030;
    exp_gnt(3'b100, 1'b0, 16'h0003, '0); exp_rd(3'b100, 32'h1000_0003);
    tick();
    dbg_req = 1'b0;
    exp_gnt(3'b010, 1'b0, 16'h0020, '0); exp_rd(3'b010, 32'hA5A5_0020);
    tick();
    idle();
    tick();
    tick();
    tick();

    chk("gnt_left", 32'(exp_g.size()), 32'd0);
    chk("rvalid_left", 32'(exp_r.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
